pi_duty_ctrl: RTL

- Discrete PI regulator. Consumes one ADC voltage sample per `sample_valid` strobe, e.g. from the `cur_vd` ramp source or the real ADC front end.
- Computes error = setpoint − sample and runs a saturating PI update.
- Emits a clamped unsigned duty word, with a one-cycle valid pulse, to the downstream PWM generator.
- Multi-cycle FSM; one sample in flight at a time.

---
 rtl/pi_ctrl_pkg.sv | 29 ++
 rtl/pi_duty_ctrl_sat_add.sv | 29 ++
 rtl/pi_duty_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pi_ctrl_pkg.sv
// Shared types and saturation limits for the PI duty regulator.
package pi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    INTEG,
    SUM,
    CLAMP
  } state_e;

  // Symmetric signed limit: +/-(2^(w-1)-1), so negation never overflows.
  function automatic int int_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int int_min(input int w);
    return -int_max(w);
  endfunction

  function automatic int duty_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int INT_MAX  = int_max(18);
  localparam int INT_MIN  = int_min(18);
  localparam int DUTY_MAX = duty_max(10);

endpackage

// File: rtl/pi_duty_ctrl_sat_add.sv
// Signed adder with symmetric saturation; the sum is formed one bit wider
// than the widest operand so the overflow test itself cannot wrap.
module sat_add_s
  import pi_ctrl_pkg::*;
#(
  parameter int A_W = 18,
  parameter int B_W = 17,
  parameter int Y_W = 18
) (
  input  logic signed [A_W-1:0] a_i,
  input  logic signed [B_W-1:0] b_i,
  output logic signed [Y_W-1:0] y_o
);

  localparam int SW = ((A_W > B_W) ? A_W : B_W) + 1;
  localparam logic signed [SW-1:0] POS = SW'(int_max(Y_W));
  localparam logic signed [SW-1:0] NEG = -POS;

  logic signed [SW-1:0] sum;

  assign sum = SW'(a_i) + SW'(b_i);

  always_comb begin
    if (sum > POS)      y_o = Y_W'(POS);
    else if (sum < NEG) y_o = Y_W'(NEG);
    else                y_o = Y_W'(sum);
  end

endmodule

// File: rtl/pi_duty_ctrl.sv
// Discrete PI regulator: one ADC sample in, one clamped duty word out,
// four cycles after the sample is accepted.
//
//   state | meaning
//   IDLE  | waiting for sample_valid & enable
//   ERR   | e = setpoint - sample
//   INTEG | integ <= sat(integ + ki*e)
//   SUM   | u = (kp*e + integ) >>> FRAC_BITS
//   CLAMP | duty <= clamp(u), duty_valid pulse
module pi_duty_ctrl
  import pi_ctrl_pkg::*;
#(
  parameter int ADC_WIDTH  = 8,
  parameter int COEF_WIDTH = 8,
  parameter int FRAC_BITS  = 4,
  parameter int DUTY_WIDTH = 10,
  parameter int INT_WIDTH  = 18
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  enable,
  input  logic                  sample_valid,
  input  logic [ADC_WIDTH-1:0]  sample,
  input  logic [ADC_WIDTH-1:0]  setpoint,
  input  logic [COEF_WIDTH-1:0] kp,
  input  logic [COEF_WIDTH-1:0] ki,
  output logic [DUTY_WIDTH-1:0] duty,
  output logic                  duty_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int EW = ADC_WIDTH + 1;
  localparam int PW = ADC_WIDTH + COEF_WIDTH + 1;
  localparam int UW = INT_WIDTH + 2;
  localparam logic signed [UW-1:0] U_DUTY_MAX = UW'(duty_max(DUTY_WIDTH));
  localparam logic [DUTY_WIDTH-1:0] DUTY_TOP = '1;

  state_e state_q, state_d;

  logic [ADC_WIDTH-1:0]        sample_q, setpoint_q;
  logic [COEF_WIDTH-1:0]       kp_q, ki_q;
  logic signed [EW-1:0]        err_q, err_d;
  logic signed [INT_WIDTH-1:0] integ_q, integ_d;
  logic signed [UW-1:0]        u_q, u_d;
  logic [DUTY_WIDTH-1:0]       duty_q, duty_d;
  logic                        duty_valid_q, overrun_q;

  logic                 accept;
  logic signed [PW-1:0] err_ext, ki_ext, kp_ext, ki_prod, kp_prod;
  logic signed [UW-1:0] kp_prod_ext, integ_ext;

  assign accept = (state_q == IDLE) && sample_valid && enable;

  assign err_d   = $signed(EW'(setpoint_q)) - $signed(EW'(sample_q));
  assign err_ext = PW'(err_q);
  assign ki_ext  = $signed(PW'(ki_q));
  assign kp_ext  = $signed(PW'(kp_q));
  assign ki_prod = ki_ext * err_ext;
  assign kp_prod = kp_ext * err_ext;

  sat_add_s #(
    .A_W(INT_WIDTH),
    .B_W(PW),
    .Y_W(INT_WIDTH)
  ) u_sat_add (
    .a_i(integ_q),
    .b_i(ki_prod),
    .y_o(integ_d)
  );

  // In SUM, integ_q already holds the value written during INTEG.
  assign kp_prod_ext = UW'(kp_prod);
  assign integ_ext   = UW'(integ_q);
  assign u_d         = (kp_prod_ext + integ_ext) >>> FRAC_BITS;

  always_comb begin
    if (u_q[UW-1])            duty_d = '0;
    else if (u_q > U_DUTY_MAX) duty_d = DUTY_TOP;
    else                      duty_d = u_q[DUTY_WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_valid && enable) state_d = ERR;
      ERR:     state_d = INTEG;
      INTEG:   state_d = SUM;
      SUM:     state_d = CLAMP;
      CLAMP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      sample_q     <= '0;
      setpoint_q   <= '0;
      kp_q         <= '0;
      ki_q         <= '0;
      err_q        <= '0;
      integ_q      <= '0;
      u_q          <= '0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (!enable) begin
      state_q      <= IDLE;
      integ_q      <= '0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      duty_valid_q <= 1'b0;
      overrun_q    <= sample_valid && (state_q != IDLE);
      if (accept) begin
        sample_q   <= sample;
        setpoint_q <= setpoint;
        kp_q       <= kp;
        ki_q       <= ki;
      end
      if (state_q == ERR)   err_q   <= err_d;
      if (state_q == INTEG) integ_q <= integ_d;
      if (state_q == SUM)   u_q     <= u_d;
      if (state_q == CLAMP) begin
        duty_q       <= duty_d;
        duty_valid_q <= 1'b1;
      end
    end
  end

  assign duty       = duty_q;
  assign duty_valid = duty_valid_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = overrun_q;

endmodule
